// File: rtl/rand_range_reducer.sv
// -----------------------------------------------------------------------------
// rand_range_reducer
//   Reduces a live LFSR word into [0, limit-1] for bounded game picks such as
//   spawn positions and lanes. A request latches the current random word and
//   the bound. A restoring shift-subtract remainder then runs for exactly
//   WIDTH cycles, and the result is presented on a valid/ready handshake.
//   limit==0 passes the captured word through unchanged, with the same latency.
//
//   Optional feature (macro RAND_NO_REPEAT_EN): when a result equals the last
//   delivered value and lim>1, the word is recaptured and the remainder is
//   recomputed. This happens at most MAX_RETRY times per request.
//
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   asynchronous active-low reset
//   rnd_in     in   live random word from the LFSR stage
//   limit      in   exclusive upper bound, sampled with req
//   req        in   request a new bounded value
//   req_ready  out  high only while idle
//   out_value  out  reduced result
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
// -----------------------------------------------------------------------------
module rand_range_reducer #(
   parameter int WIDTH     = 13,
   parameter int MAX_RETRY = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] rnd_in,
   input  logic [WIDTH-1:0] limit,
   input  logic             req,
   output logic             req_ready,
   output logic [WIDTH-1:0] out_value,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] lim;
   logic [WIDTH:0]   rem;        // one spare bit so t never overflows
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   t;
   logic [WIDTH:0]   rem_step;
   logic             last;
   logic             retry_go;

   // Remainder stays below lim, so the top bit only feeds the compare width.
   logic unused_rem_msb;
   assign unused_rem_msb = rem[WIDTH];

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   assign t        = {rem[WIDTH-1:0], dividend[WIDTH-1]};
   assign rem_step = ((lim != '0) && (t >= {1'b0, lim})) ? (t - {1'b0, lim}) : t;
   assign last     = (cnt == CW'(WIDTH-1));
   assign req_ready = (state == IDLE);

`ifdef RAND_NO_REPEAT_EN
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   logic [WIDTH-1:0] prev;
   logic [RW-1:0]    retry;

   // Recompute instead of delivering a repeat, until retries run out.
   assign retry_go = last && (lim > WIDTH'(1)) &&
                     (rem_step[WIDTH-1:0] == prev) && (retry < RW'(MAX_RETRY));
`else
   logic unused_retry_cfg;
   assign unused_retry_cfg = (MAX_RETRY > 0);
   assign retry_go = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req) state_next = CALC;
         CALC:    if (last && !retry_go) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dividend  <= '0;
         lim       <= '0;
         rem       <= '0;
         cnt       <= '0;
         out_value <= '0;
         out_valid <= 1'b0;
`ifdef RAND_NO_REPEAT_EN
         prev      <= '0;
         retry     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  dividend <= rnd_in;
                  lim      <= limit;
                  rem      <= '0;
                  cnt      <= '0;
               end
            end
            CALC: begin
               if (retry_go) begin
                  dividend <= rnd_in;
                  rem      <= '0;
                  cnt      <= '0;
`ifdef RAND_NO_REPEAT_EN
                  retry    <= retry + RW'(1);
`endif
               end else begin
                  rem      <= rem_step;
                  dividend <= dividend << 1;
                  cnt      <= cnt + CW'(1);
                  if (last) begin
                     out_value <= rem_step[WIDTH-1:0];
                     out_valid <= 1'b1;
`ifdef RAND_NO_REPEAT_EN
                     retry     <= '0;
`endif
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
`ifdef RAND_NO_REPEAT_EN
                  prev      <= out_value;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rand_range_reducer.sv
module tb_rand_range_reducer;

   localparam int W = 13;
`ifdef RAND_NO_REPEAT_EN
   localparam bit NR = 1'b1;
`else
   localparam bit NR = 1'b0;
`endif

   logic         clock;
   logic         reset;
   logic [W-1:0] rnd_in;
   logic [W-1:0] limit;
   logic         req;
   logic         req_ready;
   logic [W-1:0] out_value;
   logic         out_valid;
   logic         out_ready;

   int checks = 0;
   int errors = 0;

   rand_range_reducer #(.WIDTH(W), .MAX_RETRY(2)) dut (
      .clock     (clock),
      .reset     (reset),
      .rnd_in    (rnd_in),
      .limit     (limit),
      .req       (req),
      .req_ready (req_ready),
      .out_value (out_value),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Wait for out_valid, bounded; returns edges counted since the accept edge.
   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   // Full transaction. With alt set, rnd_in/limit change right after acceptance.
   task automatic do_req(input string tag, input int r, input int l,
                         input int exp_v, input int exp_lat,
                         input bit alt, input int ar, input int al);
      int n;
      rnd_in    = W'(r);
      limit     = W'(l);
      out_ready = 1'b0;
      req       = 1'b1;
      chk({tag, ".rdy_before"}, int'(req_ready), 1);
      @(posedge clock); #1;
      req = 1'b0;
      chk({tag, ".rdy_drop"}, int'(req_ready), 0);
      if (alt) begin
         rnd_in = W'(ar);
         limit  = W'(al);
      end
      wait_valid(n);
      chk({tag, ".lat"}, n, exp_lat);
      chk({tag, ".val"}, int'(out_value), exp_v);
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      chk({tag, ".vld_clr"}, int'(out_valid), 0);
      chk({tag, ".rdy_back"}, int'(req_ready), 1);
   endtask

   initial begin
      int n;
      reset     = 1'b0;
      rnd_in    = '0;
      limit     = '0;
      req       = 1'b0;
      out_ready = 1'b0;
      #3;
      chk("rst.vld", int'(out_valid), 0);
      chk("rst.val", int'(out_value), 0);
      chk("rst.rdy", int'(req_ready), 1);
      #9 reset = 1'b1;
      @(posedge clock); #1;

      // Basic and boundary reductions.
      do_req("basic",  6844, 100,  44,   13, 1'b0, 0, 0);
      do_req("lim0",   15,   0,    15,   13, 1'b0, 0, 0);
      do_req("lim1",   8191, 1,    0,    13, 1'b0, 0, 0);
      do_req("max_a",  8190, 8191, 8190, 13, 1'b0, 0, 0);
      do_req("max_b",  8191, 8191, 0,    13, 1'b0, 0, 0);

      // Backpressure: result held while out_ready is low and inputs churn.
      rnd_in = W'(6844);
      limit  = W'(100);
      req    = 1'b1;
      @(posedge clock); #1;
      wait_valid(n);
      chk("bp.lat", n, 13);
      chk("bp.val", int'(out_value), 44);
      for (int i = 0; i < 5; i++) begin
         req    = 1'b1;
         rnd_in = W'($urandom_range(8191, 0));
         limit  = W'(i + 3);
         @(posedge clock); #1;
         chk("bp.hold_val", int'(out_value), 44);
         chk("bp.hold_vld", int'(out_valid), 1);
         chk("bp.hold_rdy", int'(req_ready), 0);
      end
      req       = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      chk("bp.vld_clr", int'(out_valid), 0);
      chk("bp.val_keep", int'(out_value), 44);
      chk("bp.rdy_back", int'(req_ready), 1);

      do_req("sep",    8190, 8191, 8190, 13, 1'b0, 0, 0);
      // Inputs change after acceptance and must not matter.
      do_req("iso",    6844, 100,  44,   13, 1'b1, 0, 7);

      // Reset asserted between edges, six edges into CALC.
      rnd_in = W'(6844);
      limit  = W'(100);
      req    = 1'b1;
      @(posedge clock); #1;
      req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
      end
      #3 reset = 1'b0;
      #1;
      chk("mid_rst.vld", int'(out_valid), 0);
      chk("mid_rst.val", int'(out_value), 0);
      chk("mid_rst.rdy", int'(req_ready), 1);
      #2 reset = 1'b1;
      @(posedge clock); #1;
      do_req("post_rst", 6844, 100, 44, 13, 1'b0, 0, 0);

      // Repeated result: recomputed when the no-repeat feature is built in.
      do_req("repeat",   6844, 100, 44, NR ? 39 : 13, 1'b0, 0, 0);
      do_req("retry_new", 6844, 100, NR ? 45 : 44, NR ? 26 : 13, 1'b1, 6845, 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rand_range_reducer.md
Name: rand_range_reducer

Overview:
- Downstream consumer of the 13-bit LFSR random source `rnd`.
- On request, it latches the current random word and a runtime bound, then computes `word mod limit` with a fixed-latency restoring shift-subtract remainder.
- It presents the result on a valid/ready handshake.
- Game logic uses it for bounded picks such as spawn positions and lanes.

Parameters:
- WIDTH, 13: width of the random word, the bound and the result.
- MAX_RETRY, 2: maximum recomputations per request when RAND_NO_REPEAT_EN is defined.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- rnd_in  input  WIDTH  live random word from the LFSR stage.
- limit  input  WIDTH  exclusive upper bound; sampled with req.
- req  input  1  request a new bounded value.
- req_ready  output  1  high only in IDLE; a request is accepted on an edge where req and req_ready are both high.
- out_value  output  WIDTH  result, in range [0, limit-1], or rnd_in unchanged when limit==0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (asynchronous, active-low) values:
  - state=IDLE, out_valid=0, out_value=0, req_ready=1.
  - Internal dividend, remainder, bit counter, retry counter and previous-value register all cleared.
- IDLE:
  - On the edge with req=1, capture dividend<=rnd_in and lim<=limit.
  - Also set rem<=0 (WIDTH+1 bits), cnt<=0, and move to CALC.
  - req_ready drops in the following cycle.
- CALC: one bit per edge, exactly WIDTH edges.
  - t = {rem[WIDTH-1:0], dividend[WIDTH-1]}.
  - If lim!=0 and t>=lim, then rem<=t-lim; otherwise rem<=t.
  - dividend<=dividend<<1; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1:
    - out_value<=final rem[WIDTH-1:0].
    - out_valid<=1.
    - Move to DONE.
- Latency: out_valid is first high in the cycle following the 13th CALC edge, i.e. 13 clock edges after the accepting edge when WIDTH=13.
- limit==0: no subtraction ever occurs, so out_value equals the captured rnd_in. Latency is unchanged.
- limit==1: result is always 0.
- The remainder register is WIDTH+1 bits, so t never overflows for any limit up to 2^WIDTH-1.
- DONE:
  - out_value and out_valid are held stable while out_ready=0.
  - On the edge with out_ready=1: out_valid<=0, state->IDLE.
  - out_value keeps its last value after the handshake.
- req is ignored outside IDLE; there is no queuing.
- A new request is accepted no earlier than the edge after the output handshake.
- rnd_in and limit changing during CALC/DONE have no effect (captured values are used).
- Reset asserted mid-CALC or mid-DONE: immediate return to reset values; any partial result is discarded.

Optional Feature:
- Macro: RAND_NO_REPEAT_EN.
- When defined, at the end of CALC with lim>1, the result is compared against prev (the last value delivered by a handshake):
  - If equal and retry<MAX_RETRY: recapture dividend<=rnd_in, clear rem and cnt, increment retry, and stay in CALC. out_valid stays 0.
  - Otherwise: deliver the result and clear retry.
  - prev updates on each completed output handshake.
- Worst-case latency: 13×(MAX_RETRY+1) = 39 edges.
- When undefined: no comparison, no prev register, fixed 13-edge latency.

Test Plan:
- Basic reduction:
  - Stimulus: after reset, rnd_in=13'h1ABC (6844), limit=100, req pulse, out_ready=1.
  - Response: out_valid high exactly 13 edges after acceptance with out_value=44; then IDLE, req_ready=1.
- Boundary bounds:
  - limit=0 with rnd_in=13'h000F: out_value=15.
  - limit=1 with rnd_in=13'h1FFF: out_value=0.
  - limit=8191 with rnd_in=8191: out_value=0.
  - limit=8191 with rnd_in=8190: out_value=8190.
- Backpressure:
  - Stimulus: result 44 ready, out_ready held 0 for 5 cycles while req=1 and rnd_in/limit are toggled.
  - Response: out_value stays 44, out_valid stays 1, req_ready stays 0. The first out_ready=1 edge clears out_valid.
- Input isolation:
  - Stimulus: change rnd_in to 0 and limit to 7 on the cycle after acceptance of (6844, 100).
  - Response: out_value=44.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously (between edges) 6 edges into CALC.
  - Response: out_valid=0, out_value=0, req_ready=1 immediately. A following request for (6844, 100) yields 44 after 13 edges.
- RAND_NO_REPEAT_EN:
  - Stimulus: rnd_in held at 6844, limit=100, two consecutive requests, each fully handshaken.
  - Response: the first yields 44 at 13 edges. The second yields 44 after 39 edges (retries exhausted).
  - With rnd_in=6845 presented at the first retry, the second yields 45 after 26 edges.
